// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared constants and helpers for the add/sub normalisation stage
package add_sub_pkg;
  function automatic int emax(input int size_exp);
    return (1 << size_exp) - 1;
  endfunction
endpackage

// File: rtl/add_sub_lzc.sv
// add_sub_lzc: combinational leading-zero count with all-zero flag
module add_sub_lzc #(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_LOPD = $clog2(SIZE_DATA)
) (
  input  logic [SIZE_DATA-1:0] data,
  output logic [SIZE_LOPD-1:0] lz,
  output logic                 zero
);
  // scan upward so the highest set bit has the final say
  always_comb begin
    lz = '0;
    for (int i = 0; i < SIZE_DATA; i++) if (data[i]) lz = SIZE_LOPD'(SIZE_DATA - 1 - i);
    zero = ~|data;
  end
endmodule

// File: rtl/add_sub_nor_pipe.sv
// add_sub_nor_pipe: two-stage normalisation of adder mantissa/exponent with backpressure
module add_sub_nor_pipe
  import add_sub_pkg::*;
#(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_LOPD = $clog2(SIZE_DATA)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_overflow,
  input  logic [SIZE_DATA-1:0] i_mantissa,
  input  logic [SIZE_EXP-1:0]  i_exponent,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_mantissa,
  output logic [SIZE_EXP-1:0]  o_exponent,
  output logic                 o_zero,
  output logic                 o_exp_overflow,
  output logic                 o_underflow
);
  localparam int EMAX_I = emax(SIZE_EXP);
  localparam int CW = (SIZE_EXP > SIZE_LOPD ? SIZE_EXP : SIZE_LOPD) + 1;
  localparam logic [SIZE_EXP-1:0] EMAX = SIZE_EXP'(EMAX_I);
  typedef struct packed {
    logic                 zero;
    logic                 ovf;
    logic [SIZE_LOPD-1:0] lz;
    logic [SIZE_DATA-1:0] mantissa;
    logic [SIZE_EXP-1:0]  exponent;
  } s1_t;
  logic                 s1_valid, s1_en, s2_en, lz_zero, under, sat;
  logic [SIZE_LOPD-1:0] lz;
  logic [CW-1:0]        lz_w, e_w, sh;
  logic [SIZE_DATA-1:0] m_n;
  logic [SIZE_EXP-1:0]  e_n;
  s1_t                  s1, s1_d;
  assign s2_en   = !o_valid || i_ready;
  assign s1_en   = !s1_valid || s2_en;
  assign o_ready = s1_en;
  add_sub_lzc #(.SIZE_DATA(SIZE_DATA), .SIZE_LOPD(SIZE_LOPD)) u_lzc (
    .data(i_mantissa),
    .lz  (lz),
    .zero(lz_zero)
  );
  assign s1_d = '{zero: !i_overflow && lz_zero, ovf: i_overflow, lz: lz, mantissa: i_mantissa, exponent: i_exponent};
  // stage 1 valid bit, cleared on reset so in-flight beats are dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) s1_valid <= 1'b0;
    else if (s1_en) s1_valid <= i_valid;
  end
  // stage 1 payload, loaded only with real beats
  always_ff @(posedge i_clk) begin
    if (s1_en && i_valid) s1 <= s1_d;
  end
  // stage 2 shift amount, exponent adjust and flag decode
  always_comb begin
    lz_w  = CW'(s1.lz);
    e_w   = CW'(s1.exponent);
    under = !s1.zero && !s1.ovf && lz_w >= e_w;
    sat   = s1.ovf && e_w >= CW'(EMAX_I - 1);
    sh    = under ? e_w : lz_w;
    m_n   = s1.zero ? '0 : s1.ovf ? {1'b1, s1.mantissa[SIZE_DATA-1:1]} : s1.mantissa << sh;
    e_n   = (s1.zero || under) ? '0 : sat ? EMAX : s1.ovf ? s1.exponent + 1'b1 : SIZE_EXP'(e_w - lz_w);
  end
  // stage 2 output registers; bubbles leave the previous data in place
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid        <= 1'b0;
      o_mantissa     <= '0;
      o_exponent     <= '0;
      o_zero         <= 1'b0;
      o_exp_overflow <= 1'b0;
      o_underflow    <= 1'b0;
    end else if (s2_en) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_mantissa     <= m_n;
        o_exponent     <= e_n;
        o_zero         <= s1.zero;
        o_exp_overflow <= sat;
        o_underflow    <= under;
      end
    end
  end
endmodule

// File: tb/tb_add_sub_nor_pipe.sv
// tb_add_sub_nor_pipe: directed vector table plus stall, throughput and reset sequences
module tb_add_sub_nor_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, i_ready = 1'b1, i_overflow = 1'b0;
  logic [31:0] i_mantissa = '0;
  logic [7:0]  i_exponent = '0;
  logic        o_ready, o_valid, o_zero, o_exp_overflow, o_underflow;
  logic [31:0] o_mantissa;
  logic [7:0]  o_exponent;
  typedef struct {
    logic        ovf;
    logic [31:0] m;
    logic [7:0]  e;
    logic [31:0] xm;
    logic [7:0]  xe;
    logic        xz, xo, xu;
  } vec_t;
  typedef struct {
    logic [42:0] r;
    int          acc;
  } sb_t;
  vec_t        tab[12];
  sb_t         q[$];
  int          n_chk = 0, n_pass = 0, cyc = 0, ov_cnt = 0, n;
  logic        lat_chk = 1'b0, hold_v = 1'b0, last_acc = 1'b0;
  logic [42:0] hold;

  add_sub_nor_pipe #(.SIZE_DATA(32), .SIZE_EXP(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_overflow(i_overflow), .i_mantissa(i_mantissa), .i_exponent(i_exponent),
    .o_valid(o_valid), .i_ready(i_ready), .o_mantissa(o_mantissa),
    .o_exponent(o_exponent), .o_zero(o_zero), .o_exp_overflow(o_exp_overflow),
    .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [42:0] expect_of(input int idx);
    return {tab[idx].xm, tab[idx].xe, tab[idx].xz, tab[idx].xo, tab[idx].xu};
  endfunction

  task automatic step(input logic v, input int idx, input logic rdy);
    sb_t         s;
    logic [42:0] got;
    logic        exp_rdy;
    @(posedge clk);
    cyc++;
    #1;
    i_valid    = v;
    i_ready    = rdy;
    i_overflow = tab[idx].ovf;
    i_mantissa = tab[idx].m;
    i_exponent = tab[idx].e;
    #1;
    got     = {o_mantissa, o_exponent, o_zero, o_exp_overflow, o_underflow};
    exp_rdy = !(q.size() == 2 && !rdy);
    check(o_ready == exp_rdy, "o_ready", 64'(o_ready), 64'(exp_rdy));
    if (hold_v) check(got == hold && o_valid, "stall_hold", 64'(got), 64'(hold));
    if (o_valid) begin
      ov_cnt++;
      check(q.size() > 0, "spurious_beat", 64'(q.size()), 64'd1);
      if (rdy && q.size() > 0) begin
        s = q.pop_front();
        check(got == s.r, "data", 64'(got), 64'(s.r));
        if (lat_chk) check(cyc - s.acc == 2, "latency", 64'(cyc - s.acc), 64'd2);
      end
    end
    hold_v   = o_valid && !rdy;
    hold     = got;
    last_acc = v && o_ready;
    if (last_acc) q.push_back('{expect_of(idx), cyc});
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && q.size() > 0; c++) step(1'b0, 0, 1'b1);
    check(q.size() == 0, "drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    tab[0]  = '{1'b0, 32'h0000_1000, 8'd100, 32'h8000_0000, 8'd81,  1'b0, 1'b0, 1'b0};
    tab[1]  = '{1'b1, 32'h8000_0003, 8'd10,  32'hC000_0001, 8'd11,  1'b0, 1'b0, 1'b0};
    tab[2]  = '{1'b1, 32'h8000_0003, 8'd254, 32'hC000_0001, 8'd255, 1'b0, 1'b1, 1'b0};
    tab[3]  = '{1'b1, 32'h8000_0003, 8'd255, 32'hC000_0001, 8'd255, 1'b0, 1'b1, 1'b0};
    tab[4]  = '{1'b0, 32'h0000_0100, 8'd10,  32'h0004_0000, 8'd0,   1'b0, 1'b0, 1'b1};
    tab[5]  = '{1'b0, 32'h0000_0000, 8'd77,  32'h0000_0000, 8'd0,   1'b1, 1'b0, 1'b0};
    tab[6]  = '{1'b0, 32'h8000_0000, 8'd5,   32'h8000_0000, 8'd5,   1'b0, 1'b0, 1'b0};
    tab[7]  = '{1'b0, 32'h0000_0001, 8'd31,  32'h8000_0000, 8'd0,   1'b0, 1'b0, 1'b1};
    tab[8]  = '{1'b0, 32'h0000_0001, 8'd32,  32'h8000_0000, 8'd1,   1'b0, 1'b0, 1'b0};
    tab[9]  = '{1'b1, 32'h0000_0000, 8'd0,   32'h8000_0000, 8'd1,   1'b0, 1'b0, 1'b0};
    tab[10] = '{1'b0, 32'h0000_00F0, 8'd0,   32'h0000_00F0, 8'd0,   1'b0, 1'b0, 1'b1};
    tab[11] = '{1'b1, 32'h0000_0002, 8'd253, 32'h8000_0001, 8'd254, 1'b0, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check(!o_valid, "reset_o_valid", 64'(o_valid), 64'd0);
    check({o_mantissa, o_exponent, o_zero, o_exp_overflow, o_underflow} == '0, "reset_outputs",
          64'({o_mantissa, o_exponent, o_zero, o_exp_overflow, o_underflow}), 64'd0);
    check(o_ready, "reset_o_ready", 64'(o_ready), 64'd1);
    lat_chk = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, i, 1'b1);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
    end
    drain();
    lat_chk = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 8; c++) begin
      step(1'b1, n, (c % 4 == 0) || (c % 4 == 3));
      if (last_acc) n++;
    end
    check(n == 8, "bp_accepted", 64'(n), 64'd8);
    drain();
    lat_chk = 1'b1;
    ov_cnt  = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i % 12, 1'b1);
      check(last_acc, "tp_accept", 64'(last_acc), 64'd1);
    end
    drain();
    check(ov_cnt == 16, "tp_valid_cycles", 64'(ov_cnt), 64'd16);
    step(1'b1, 0, 1'b1);
    step(1'b1, 1, 1'b1);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc += 2;
    q.delete();
    hold_v = 1'b0;
    #1;
    check(!o_valid, "midrst_o_valid", 64'(o_valid), 64'd0);
    check({o_mantissa, o_exponent, o_zero, o_exp_overflow, o_underflow} == '0, "midrst_outputs",
          64'({o_mantissa, o_exponent, o_zero, o_exp_overflow, o_underflow}), 64'd0);
    check(o_ready, "midrst_o_ready", 64'(o_ready), 64'd1);
    step(1'b1, 4, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
